// File: rtl/snes_controller_poller_if.sv
// Bus bundle for snes_controller_poller: pad pins plus the decoded button word.
// master = poller side, slave = controller pins / downstream consumer side.
interface snes_controller_poller_if #(
  parameter int unsigned NUM_BITS = 16
);
  logic                enable;
  logic                snes_data_in;
  logic                snes_latch_out;
  logic                snes_clk_out;
  logic [NUM_BITS-1:0] buttons;
  logic                valid;
  logic                busy;
  logic                connected;

  modport master (
    input  enable, snes_data_in,
    output snes_latch_out, snes_clk_out, buttons, valid, busy, connected
  );

  modport slave (
    output enable, snes_data_in,
    input  snes_latch_out, snes_clk_out, buttons, valid, busy, connected
  );
endinterface

// File: rtl/snes_controller_poller.sv
// Console-side SNES pad poller: periodic latch/clock burst, active-low serial in, active-high word out.
// Optional macro SNES_PRESENCE_EN: report pad presence from ID bits 12..15 and mask buttons when absent.
module snes_controller_poller #(
  parameter int unsigned NUM_BITS     = 16,
  parameter int unsigned HALF_CYCLES  = 13,
  parameter int unsigned LATCH_CYCLES = 25,
  parameter int unsigned POLL_PERIOD  = 34667
) (
  input logic clock,
  input logic reset,
  snes_controller_poller_if.master bus
);
  localparam int unsigned CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned TMR_W   = $clog2(POLL_PERIOD);
  localparam int unsigned BIT_W   = $clog2(NUM_BITS);

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {IDLE, LATCH, LEAD, LOW, HIGH, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [TMR_W-1:0]    timer;
  logic [BIT_W-1:0]    bit_idx;
  logic [NUM_BITS-2:0] shift_reg;
  logic [NUM_BITS-1:0] shifted;
  logic                data_meta;
  logic                data_sync;
  logic                latch_q;
  logic                clk_q;
  logic [NUM_BITS-1:0] buttons_q;
  logic                valid_q;
  logic                busy_q;
  logic                connected_q;

  // Bits enter at the top and move down, so bit 0 (B) ends at index 0 after the last sample.
  assign shifted = {data_sync, shift_reg};

`ifdef SNES_PRESENCE_EN
  logic pad_ok;
  assign pad_ok = (shifted[15:12] == 4'hF);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      timer       <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      data_meta   <= 1'b1;
      data_sync   <= 1'b1;
      latch_q     <= 1'b0;
      clk_q       <= 1'b1;
      buttons_q   <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      connected_q <= 1'b0;
    end else begin
      timer     <= (timer == TMR_LAST) ? '0 : timer + TMR_W'(1);
      data_meta <= bus.snes_data_in;
      data_sync <= data_meta;
      valid_q   <= 1'b0;
      // Outputs are updated on the same edge as the state, so they track the state register exactly.
      case (state)
        IDLE: begin
          if (timer == TMR_LAST && bus.enable) begin
            state   <= LATCH;
            cnt     <= '0;
            latch_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LATCH: begin
          if (cnt == LATCH_LAST) begin
            state   <= LEAD;
            cnt     <= '0;
            latch_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LEAD: begin
          if (cnt == HALF_LAST) begin
            shift_reg <= shifted[NUM_BITS-1:1];
            bit_idx   <= BIT_W'(1);
            state     <= LOW;
            cnt       <= '0;
            clk_q     <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt == HALF_LAST) begin
            state <= HIGH;
            cnt   <= '0;
            clk_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (cnt == HALF_LAST) begin
            cnt       <= '0;
            shift_reg <= shifted[NUM_BITS-1:1];
            if (bit_idx == BIT_LAST) begin
              state   <= DONE;
              valid_q <= 1'b1;
`ifdef SNES_PRESENCE_EN
              connected_q <= pad_ok;
              buttons_q   <= pad_ok ? ~shifted : '0;
`else
              connected_q <= 1'b1;
              buttons_q   <= ~shifted;
`endif
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              state   <= LOW;
              clk_q   <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.snes_latch_out = latch_q;
  assign bus.snes_clk_out   = clk_q;
  assign bus.buttons        = buttons_q;
  assign bus.valid          = valid_q;
  assign bus.busy           = busy_q;
  assign bus.connected      = connected_q;
endmodule

// File: tb/tb_snes_controller_poller.sv
// Bench for snes_controller_poller: behavioural pad plus waveform-level checks of each poll.
module tb_snes_controller_poller;
  localparam int NB     = 16;
  localparam int HALF   = 3;
  localparam int LATCH  = 4;
  localparam int PERIOD = 200;
  localparam int POLL_LEN = LATCH + HALF * (2 * NB - 1) + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   edges = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [15:0] pad_raw = 16'hFFFF;
  logic [15:0] pad_sr  = 16'hFFFF;

  snes_controller_poller_if #(.NUM_BITS(NB)) bus ();

  snes_controller_poller #(
    .NUM_BITS(NB),
    .HALF_CYCLES(HALF),
    .LATCH_CYCLES(LATCH),
    .POLL_PERIOD(PERIOD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  // Pad: parallel load while latch rises, shift toward the data pin on each clk rising edge.
  always @(posedge bus.snes_latch_out or posedge bus.snes_clk_out) begin
    if (bus.snes_latch_out) pad_sr = pad_raw;
    else                    pad_sr = {1'b1, pad_sr[15:1]};
  end
  assign bus.snes_data_in = pad_sr[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_buttons(input logic [15:0] raw);
`ifdef SNES_PRESENCE_EN
    return (raw[15:12] == 4'hF) ? ~raw : 16'h0000;
`else
    return ~raw;
`endif
  endfunction

  function automatic logic exp_connected(input logic [15:0] raw);
`ifdef SNES_PRESENCE_EN
    return raw[15:12] == 4'hF;
`else
    return 1'b1;
`endif
  endfunction

  task automatic wait_latch(output int waited);
    waited = 0;
    while (!bus.snes_latch_out && waited < 500) begin
      @(negedge clock);
      waited++;
    end
    check("poll_start", waited < 500, 1);
    check("start_on_wrap", edges % PERIOD, 0);
  endtask

  // Observes one whole poll from the first latch-high cycle; drop_at >= 0 deasserts enable at that offset.
  task automatic run_poll(input logic [15:0] raw, input int drop_at);
    int waited, latch_len, busy_len, valid_n, valid_at, lows, bad_low, low_run;
    logic [15:0] btn_seen;
    logic conn_seen;
    latch_len = 0; busy_len = 0; valid_n = 0; valid_at = -1;
    lows = 0; bad_low = 0; low_run = 0;
    btn_seen = '0; conn_seen = 1'b0;
    pad_raw = raw;
    wait_latch(waited);
    for (int i = 0; i < 120; i++) begin
      if (i > 0) @(negedge clock);
      if (i == drop_at) bus.enable = 1'b0;
      latch_len += int'(bus.snes_latch_out);
      busy_len  += int'(bus.busy);
      if (bus.valid) begin
        valid_n++;
        valid_at  = i;
        btn_seen  = bus.buttons;
        conn_seen = bus.connected;
      end
      if (!bus.snes_clk_out) low_run++;
      else if (low_run > 0) begin
        lows++;
        if (low_run != HALF) bad_low++;
        low_run = 0;
      end
    end
    check("latch_len", latch_len, LATCH);
    check("clk_low_pulses", lows, NB - 1);
    check("clk_low_width_bad", bad_low, 0);
    check("valid_count", valid_n, 1);
    check("valid_offset", valid_at, POLL_LEN - 1);
    check("busy_len", busy_len, POLL_LEN);
    check("buttons", btn_seen, exp_buttons(raw));
    check("connected", conn_seen, exp_connected(raw));
    check("buttons_hold", bus.buttons, exp_buttons(raw));
  endtask

  initial begin
    int waited, latch_seen;
    logic [15:0] raw;
    bus.enable = 1'b0;

    repeat (5) @(negedge clock);
    check("rst_latch", bus.snes_latch_out, 0);
    check("rst_clk", bus.snes_clk_out, 1);
    check("rst_buttons", bus.buttons, 16'h0000);
    check("rst_valid", bus.valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_connected", bus.connected, 0);

    reset = 1'b0;
    bus.enable = 1'b1;
    run_poll(16'hFFF6, -1);

    for (int n = 0; n < 6; n++) begin
      raw = 16'($urandom);
      if ($urandom_range(0, 1) == 1) raw[15:12] = 4'hF;
      run_poll(raw, -1);
    end

    run_poll(16'($urandom), 40);
    latch_seen = 0;
    repeat (250) begin
      @(negedge clock);
      latch_seen += int'(bus.snes_latch_out);
    end
    check("no_poll_when_disabled", latch_seen, 0);
    bus.enable = 1'b1;
    run_poll(16'hFFF6, -1);

    // Reset in the middle of bit 7's low phase (offset 43..45 from latch rise).
    pad_raw = 16'($urandom);
    wait_latch(waited);
    repeat (44) @(negedge clock);
    check("mid_low_clk", bus.snes_clk_out, 0);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_clk", bus.snes_clk_out, 1);
    check("midrst_latch", bus.snes_latch_out, 0);
    check("midrst_buttons", bus.buttons, 16'h0000);
    check("midrst_busy", bus.busy, 0);
    check("midrst_valid", bus.valid, 0);
    repeat (3) begin
      @(negedge clock);
      check("midrst_valid_hold", bus.valid, 0);
    end
    reset = 1'b0;

    run_poll(16'h0000, -1);
    run_poll(16'hF0FE, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
